// File: rtl/cpu_pkg.sv
// Shared CPU definitions: store-buffer FSM states and the word-address
// slice constants used by the ROB, store buffer and data cache.
package cpu_pkg;

   localparam int CPU_ADDR_W = 32;
   localparam int CPU_DATA_W = 32;

   // Lowest address bit that takes part in word-granular matching
   localparam int WORD_LSB = 2;

   typedef enum logic [0:0] {
      SB_IDLE = 1'b0,
      SB_REQ  = 1'b1
   } sb_state_e;

endpackage : cpu_pkg

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding selector. Entries are scanned
// in age order starting at tail (oldest slot position) and wrapping, so
// the last matching slot seen is the one closest to tail-1 (youngest).
module sb_fwd_match
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WORD_W = 30,
   parameter int DATA_W = 32
) (
   input  logic [DEPTH-1:0]         ent_valid,
   input  logic [WORD_W-1:0]        ent_word [DEPTH],
   input  logic [DATA_W-1:0]        ent_data [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] tail,
   input  logic [WORD_W-1:0]        ld_word,
   output logic                     hit,
   output logic [DATA_W-1:0]        hit_data
);

   localparam int PTR_W = $clog2(DEPTH);

   // Priority select: younger matches overwrite older ones
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         logic [PTR_W-1:0] idx;
         idx = tail + PTR_W'(k);
         if (ent_valid[idx] && (ent_word[idx] == ld_word)) begin
            hit      = 1'b1;
            hit_data = ent_data[idx];
         end else begin
            hit      = hit;
            hit_data = hit_data;
         end
      end
   end

endmodule : sb_fwd_match

// File: rtl/commit_store_buffer.sv
// Post-commit store buffer: in-order FIFO of retired word stores drained
// to memory through a req/ack handshake, with youngest-match forwarding
// to loads and an empty indication for fences.
module commit_store_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DATA_W = CPU_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     commit_valid,
   input  logic [ADDR_W-1:0]        commit_addr,
   input  logic [DATA_W-1:0]        commit_data,
   output logic                     commit_ready,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ack,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic                     ld_hit,
   output logic [DATA_W-1:0]        ld_data,
   output logic                     sb_empty,
   output logic [$clog2(DEPTH):0]   sb_count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WORD_W = ADDR_W - WORD_LSB;

   logic [DEPTH-1:0]  valid_r;
   logic [ADDR_W-1:0] addr_r [DEPTH];
   logic [DATA_W-1:0] data_r [DEPTH];
   logic [WORD_W-1:0] ent_word_s [DEPTH];
   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [PTR_W-1:0]  head_next_s;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   sb_state_e         state_r;
   logic              commit_ready_r;
   logic              mem_req_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              sb_empty_r;
   logic              push_s;
   logic              pop_s;
   logic [ADDR_W-1:0] nxt_addr_s;
   logic [DATA_W-1:0] nxt_data_s;
   logic              ld_addr_unused_s;

   // Byte-offset bits never participate in forwarding
   assign ld_addr_unused_s = ^ld_addr[WORD_LSB-1:0];

   assign push_s      = commit_valid && commit_ready_r;
   assign pop_s       = (state_r == SB_REQ) && mem_ack;
   assign head_next_s = head_r + PTR_W'(1);

   // Occupancy after this edge's push and/or pop
   always_comb begin
      count_next_s = count_r;
      if (push_s && !pop_s) begin
         count_next_s = count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CNT_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Entry following the head; with one entry left it may be arriving right now
   always_comb begin
      nxt_addr_s = addr_r[head_next_s];
      nxt_data_s = data_r[head_next_s];
      if (push_s && (count_r == CNT_W'(1))) begin
         nxt_addr_s = commit_addr;
         nxt_data_s = commit_data;
      end else begin
         nxt_addr_s = addr_r[head_next_s];
         nxt_data_s = data_r[head_next_s];
      end
   end

   // Entry payload storage, written at tail on push
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_r[tail_r] <= commit_addr;
         data_r[tail_r] <= commit_data;
      end
   end

   // Valid bits, pointers, occupancy and back-pressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r        <= '0;
         head_r         <= '0;
         tail_r         <= '0;
         count_r        <= '0;
         commit_ready_r <= 1'b1;
      end else begin
         if (push_s) begin
            valid_r[tail_r] <= 1'b1;
            tail_r          <= tail_r + PTR_W'(1);
         end
         if (pop_s) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_next_s;
         end
         count_r        <= count_next_s;
         commit_ready_r <= (count_next_s != CNT_W'(DEPTH));
      end
   end

   // Drain FSM: present head entry to memory and hold it until acknowledged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= SB_IDLE;
         mem_req_r   <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         sb_empty_r  <= 1'b1;
      end else begin
         case (state_r)
            SB_IDLE: begin
               if (count_r != '0) begin
                  state_r     <= SB_REQ;
                  mem_req_r   <= 1'b1;
                  mem_addr_r  <= addr_r[head_r];
                  mem_wdata_r <= data_r[head_r];
                  sb_empty_r  <= 1'b0;
               end else begin
                  state_r    <= SB_IDLE;
                  mem_req_r  <= 1'b0;
                  sb_empty_r <= !push_s;
               end
            end
            SB_REQ: begin
               if (mem_ack) begin
                  if (count_next_s == '0) begin
                     state_r     <= SB_IDLE;
                     mem_req_r   <= 1'b0;
                     mem_addr_r  <= '0;
                     mem_wdata_r <= '0;
                     sb_empty_r  <= 1'b1;
                  end else begin
                     state_r     <= SB_REQ;
                     mem_req_r   <= 1'b1;
                     mem_addr_r  <= nxt_addr_s;
                     mem_wdata_r <= nxt_data_s;
                     sb_empty_r  <= 1'b0;
                  end
               end else begin
                  state_r    <= SB_REQ;
                  mem_req_r  <= 1'b1;
                  sb_empty_r <= 1'b0;
               end
            end
            default: begin
               state_r    <= SB_IDLE;
               mem_req_r  <= 1'b0;
               sb_empty_r <= (count_r == '0);
            end
         endcase
      end
   end

   // Word-address view of each entry for the forwarding comparators
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_word_s[i] = addr_r[i][ADDR_W-1:WORD_LSB];
      end
   end

   sb_fwd_match #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W),
      .DATA_W (DATA_W)
   ) u_fwd (
      .ent_valid (valid_r),
      .ent_word  (ent_word_s),
      .ent_data  (data_r),
      .tail      (tail_r),
      .ld_word   (ld_addr[ADDR_W-1:WORD_LSB]),
      .hit       (ld_hit),
      .hit_data  (ld_data)
   );

   assign commit_ready = commit_ready_r;
   assign mem_req      = mem_req_r;
   assign mem_addr     = mem_addr_r;
   assign mem_wdata    = mem_wdata_r;
   assign sb_empty     = sb_empty_r;
   assign sb_count     = count_r;

endmodule : commit_store_buffer

// File: tb/tb_commit_store_buffer.sv
// Directed testbench for commit_store_buffer (DEPTH=4, 32-bit address/data).
module tb_commit_store_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        commit_valid;
   logic [31:0] commit_addr;
   logic [31:0] commit_data;
   logic        commit_ready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        sb_empty;
   logic [2:0]  sb_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   commit_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .commit_valid (commit_valid),
      .commit_addr  (commit_addr),
      .commit_data  (commit_data),
      .commit_ready (commit_ready),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .ld_addr      (ld_addr),
      .ld_hit       (ld_hit),
      .ld_data      (ld_data),
      .sb_empty     (sb_empty),
      .sb_count     (sb_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      commit_valid = 1'b1;
      commit_addr  = a;
      commit_data  = d;
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; commit_valid = 1'b0; commit_addr = 32'h0; commit_data = 32'h0;
      mem_ack = 1'b0; ld_addr = 32'h0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", commit_ready); end
      checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", sb_empty); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", mem_req); end
      checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", sb_count); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
      checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld got %0b/%h exp 0/0", ld_hit, ld_data); end
   endtask

   task automatic test_single();
      push(32'h100, 32'hDEADBEEF);
      checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", sb_count); end
      checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL single_nonempty got %0b exp 0", sb_empty); end
      ld_addr = 32'h103; #1;
      checks++; if (ld_hit !== 1'b1 || ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd got %0b/%h exp 1/deadbeef", ld_hit, ld_data); end
      tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_req got %0b exp 1", mem_req); end
      checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_head got %h/%h exp 100/deadbeef", mem_addr, mem_wdata); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold%0d got %0b/%h/%h exp 1/100/deadbeef", i, mem_req, mem_addr, mem_wdata); end
      end
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || sb_empty !== 1'b1 || sb_count !== 3'd0) begin errors++; $display("FAIL single_done got req %0b empty %0b cnt %0d exp 0/1/0", mem_req, sb_empty, sb_count); end
      checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL single_fwd_gone got %0b/%h exp 0/0", ld_hit, ld_data); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) push(32'h40 + 32'(4 * i), 32'(i + 1));
      checks++; if (sb_count !== 3'd4 || commit_ready !== 1'b0) begin errors++; $display("FAIL full_state got cnt %0d rdy %0b exp 4/0", sb_count, commit_ready); end
      push(32'h50, 32'h5);
      checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d exp 4", sb_count); end
      ld_addr = 32'h50; #1;
      checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL full_reject_fwd got %0b exp 0", ld_hit); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1) begin errors++; $display("FAIL full_head got %0b/%h/%h exp 1/40/1", mem_req, mem_addr, mem_wdata); end
      mem_ack = 1'b1;
      push(32'h54, 32'h6);
      mem_ack = 1'b0;
      checks++; if (sb_count !== 3'd3 || commit_ready !== 1'b1) begin errors++; $display("FAIL full_ack_push got cnt %0d rdy %0b exp 3/1", sb_count, commit_ready); end
      checks++; if (mem_addr !== 32'h44 || mem_wdata !== 32'h2) begin errors++; $display("FAIL full_next_head got %h/%h exp 44/2", mem_addr, mem_wdata); end
      ld_addr = 32'h54; #1;
      checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL full_ack_push_fwd got %0b exp 0", ld_hit); end
      ld_addr = 32'h4C; #1;
      checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h4) begin errors++; $display("FAIL full_fwd_tail got %0b/%h exp 1/4", ld_hit, ld_data); end
      mem_ack = 1'b1;
      tick();
      checks++; if (mem_addr !== 32'h48) begin errors++; $display("FAIL full_drain1 got %h exp 48", mem_addr); end
      tick();
      checks++; if (mem_addr !== 32'h4C) begin errors++; $display("FAIL full_drain2 got %h exp 4c", mem_addr); end
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("FAIL full_drained got req %0b empty %0b exp 0/1", mem_req, sb_empty); end
   endtask

   task automatic test_forward();
      push(32'h200, 32'h1);
      push(32'h204, 32'h2);
      push(32'h200, 32'h3);
      checks++; if (mem_addr !== 32'h200 || mem_wdata !== 32'h1) begin errors++; $display("FAIL fwd_head got %h/%h exp 200/1", mem_addr, mem_wdata); end
      ld_addr = 32'h202; #1;
      checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h3) begin errors++; $display("FAIL fwd_youngest got %0b/%h exp 1/3", ld_hit, ld_data); end
      ld_addr = 32'h204; #1;
      checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h2) begin errors++; $display("FAIL fwd_mid got %0b/%h exp 1/2", ld_hit, ld_data); end
      ld_addr = 32'h208; #1;
      checks++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL fwd_miss got %0b/%h exp 0/0", ld_hit, ld_data); end
      mem_ack = 1'b1;
      tick();
      ld_addr = 32'h200; #1;
      checks++; if (ld_hit !== 1'b1 || ld_data !== 32'h3) begin errors++; $display("FAIL fwd_after_pop got %0b/%h exp 1/3", ld_hit, ld_data); end
      tick(); tick();
      mem_ack = 1'b0;
      checks++; if (sb_empty !== 1'b1 || ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_drained got empty %0b hit %0b exp 1/0", sb_empty, ld_hit); end
   endtask

   task automatic test_back_to_back();
      push(32'h10, 32'hA0);
      push(32'h14, 32'hA1);
      push(32'h18, 32'hA2);
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL b2b_first got %0b/%h exp 1/10", mem_req, mem_addr); end
      mem_ack = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h14 || mem_wdata !== 32'hA1) begin errors++; $display("FAIL b2b_second got %0b/%h/%h exp 1/14/a1", mem_req, mem_addr, mem_wdata); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h18 || mem_wdata !== 32'hA2) begin errors++; $display("FAIL b2b_third got %0b/%h/%h exp 1/18/a2", mem_req, mem_addr, mem_wdata); end
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_idle got req %0b empty %0b exp 0/1", mem_req, sb_empty); end
      push(32'h20, 32'hA);
      tick();
      mem_ack = 1'b1;
      push(32'h24, 32'hB);
      mem_ack = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h24 || mem_wdata !== 32'hB || sb_count !== 3'd1) begin errors++; $display("FAIL b2b_pushpop got %0b/%h/%h cnt %0d exp 1/24/b/1", mem_req, mem_addr, mem_wdata, sb_count); end
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_pushpop_done got %0b exp 1", sb_empty); end
   endtask

   task automatic test_wrap();
      logic [31:0] a [12];
      logic [31:0] d [12];
      for (int i = 0; i < 12; i++) begin
         a[i] = 32'h300 + 32'(4 * (i % 3));
         d[i] = 32'h1000 + 32'(i);
      end
      push(a[0], d[0]);
      push(a[1], d[1]);
      for (int k = 0; k < 10; k++) begin
         mem_ack = 1'b1;
         push(a[k + 2], d[k + 2]);
         mem_ack = 1'b0;
         checks++; if (mem_addr !== a[k + 1] || mem_wdata !== d[k + 1] || sb_count !== 3'd2) begin errors++; $display("FAIL wrap_order%0d got %h/%h cnt %0d exp %h/%h/2", k, mem_addr, mem_wdata, sb_count, a[k + 1], d[k + 1]); end
         ld_addr = a[k + 2]; #1;
         checks++; if (ld_hit !== 1'b1 || ld_data !== d[k + 2]) begin errors++; $display("FAIL wrap_fwd%0d got %0b/%h exp 1/%h", k, ld_hit, ld_data, d[k + 2]); end
         ld_addr = a[k]; #1;
         checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL wrap_popped%0d got %0b exp 0", k, ld_hit); end
      end
      mem_ack = 1'b1;
      tick();
      checks++; if (mem_addr !== a[11] || mem_wdata !== d[11]) begin errors++; $display("FAIL wrap_last got %h/%h exp %h/%h", mem_addr, mem_wdata, a[11], d[11]); end
      tick();
      mem_ack = 1'b0;
      checks++; if (sb_empty !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL wrap_drained got empty %0b req %0b exp 1/0", sb_empty, mem_req); end
   endtask

   task automatic test_reset_mid();
      push(32'h80, 32'h55);
      tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %0b exp 1", mem_req); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || sb_count !== 3'd0) begin errors++; $display("FAIL rmid_async got req %0b cnt %0d exp 0/0", mem_req, sb_count); end
      checks++; if (commit_ready !== 1'b1 || sb_empty !== 1'b1) begin errors++; $display("FAIL rmid_flags got rdy %0b empty %0b exp 1/1", commit_ready, sb_empty); end
      #1 rst_n = 1'b1;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      ld_addr = 32'h80; #1;
      checks++; if (mem_req !== 1'b0 || sb_count !== 3'd0 || ld_hit !== 1'b0) begin errors++; $display("FAIL rmid_late_ack got req %0b cnt %0d hit %0b exp 0/0/0", mem_req, sb_count, ld_hit); end
      tick();
      checks++; if (mem_req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("FAIL rmid_idle got req %0b empty %0b exp 0/1", mem_req, sb_empty); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_forward();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_commit_store_buffer
